// File: rtl/fifo_pdm_player.sv
`default_nettype none
// ============================================================================
//  Module   : fifo_pdm_player
//  Purpose  : Read-side companion of the 1-bit microphone sample FIFO. Pops
//             recorded PDM bits at a programmable sample rate and drives them
//             onto the 1-bit audio pin. Supports bounded-length playback,
//             play-until-empty, stop, underrun detection and an optional
//             FIFO flush when playback completes.
//  Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    Clk        in   1      system clock, rising edge
//    Rst        in   1      synchronous active-high reset
//    Start      in   1      begin playback (honoured in IDLE only)
//    Stop       in   1      end playback
//    Div        in   DIV_W  sample period minus 1 (latched on Start)
//    Len        in   CNT_W  samples to play, 0 = until empty (latched)
//    ClrOnDone  in   1      flush FIFO at end of playback (latched)
//    F_Data     in   1      show-ahead FIFO data
//    F_EmptyN   in   1      FIFO not-empty flag
//    FOutN      out  1      active-low FIFO read strobe
//    FClrN      out  1      active-low FIFO clear
//    Audio_Out  out  1      PDM audio bit
//    Audio_En   out  1      amplifier enable
//    Busy       out  1      playback in progress
//    Done       out  1      one-cycle end-of-playback pulse
//    Underrun   out  1      sticky: FIFO empty at a tick of bounded playback
//    Played     out  CNT_W  samples popped in current / last run
// ============================================================================
module fifo_pdm_player #(
   parameter int DIV_W = 16,
   parameter int CNT_W = 21
) (
   input  logic             Clk,
   input  logic             Rst,
   input  logic             Start,
   input  logic             Stop,
   input  logic [DIV_W-1:0] Div,
   input  logic [CNT_W-1:0] Len,
   input  logic             ClrOnDone,
   input  logic             F_Data,
   input  logic             F_EmptyN,
   output logic             FOutN,
   output logic             FClrN,
   output logic             Audio_Out,
   output logic             Audio_En,
   output logic             Busy,
   output logic             Done,
   output logic             Underrun,
   output logic [CNT_W-1:0] Played
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   state_t           state;
   state_t           state_nxt;

   logic [DIV_W-1:0] div_cnt;
   logic [DIV_W-1:0] div_lat;
   logic [CNT_W-1:0] len_lat;
   logic             clr_lat;
   logic [CNT_W-1:0] played;
   logic             underrun;
   logic             audio;

   logic             start_ok;
   logic             tick;
   logic             rd;
   logic             empty_tick;
   logic             last_read;
   logic [CNT_W-1:0] played_inc;

   // ------------------------------------------------------------------------
   // Sample-tick decode. A read happens on a tick with data present, unless
   // Stop overrides it; Rst also suppresses the strobe so that a reset cycle
   // never consumes a sample.
   // ------------------------------------------------------------------------
   always_comb begin
      start_ok   = 1'b0;
      tick       = 1'b0;
      rd         = 1'b0;
      empty_tick = 1'b0;
      last_read  = 1'b0;
      played_inc = played + CNT_W'(1);

      start_ok   = (state == ST_IDLE) && Start && !Stop;
      tick       = (state == ST_RUN) && (div_cnt == '0);
      rd         = tick && F_EmptyN && !Stop && !Rst;
      empty_tick = tick && !F_EmptyN && !Stop;
      // Bounded playback ends on the read that reaches the requested length.
      last_read  = rd && (len_lat != '0) && (played_inc == len_lat);
   end

   // ------------------------------------------------------------------------
   // Next-state and output decode
   // ------------------------------------------------------------------------
   always_comb begin
      state_nxt = state;
      FOutN     = 1'b1;
      FClrN     = 1'b1;
      Busy      = 1'b0;
      Audio_En  = 1'b0;
      Done      = 1'b0;

      case (state)
         ST_IDLE: begin
            if (start_ok) begin
               state_nxt = ST_RUN;
            end
         end
         ST_RUN: begin
            Busy     = !Rst;
            Audio_En = !Rst;
            FOutN    = !rd;
            if (Stop) begin
               state_nxt = ST_DONE;
            end else if (last_read) begin
               state_nxt = ST_DONE;
            end else if (empty_tick && (len_lat == '0)) begin
               // Play-until-empty: an empty FIFO at a tick is the normal end.
               state_nxt = ST_DONE;
            end
         end
         ST_DONE: begin
            Done      = !Rst;
            FClrN     = !(clr_lat && !Rst);
            state_nxt = ST_IDLE;
         end
         default: begin
            state_nxt = ST_IDLE;
         end
      endcase
   end

   // ------------------------------------------------------------------------
   // State and datapath registers
   // ------------------------------------------------------------------------
   always_ff @(posedge Clk) begin
      if (Rst) begin
         state    <= ST_IDLE;
         div_cnt  <= '0;
         div_lat  <= '0;
         len_lat  <= '0;
         clr_lat  <= 1'b0;
         played   <= '0;
         underrun <= 1'b0;
         audio    <= 1'b0;
      end else begin
         state <= state_nxt;
         case (state)
            ST_IDLE: begin
               if (start_ok) begin
                  div_lat  <= Div;
                  len_lat  <= Len;
                  clr_lat  <= ClrOnDone;
                  div_cnt  <= Div;
                  played   <= '0;
                  underrun <= 1'b0;
               end
            end
            ST_RUN: begin
               if (tick) begin
                  div_cnt <= div_lat;
               end else begin
                  div_cnt <= div_cnt - DIV_W'(1);
               end
               if (rd) begin
                  audio  <= F_Data;
                  played <= played_inc;
               end else if (empty_tick && (len_lat != '0)) begin
                  // Starved bounded playback: alternate the bit so the
                  // filtered output sits at mid-scale instead of a rail.
                  underrun <= 1'b1;
                  audio    <= !audio;
               end
            end
            ST_DONE: begin
               audio <= 1'b0;
            end
            default: begin
               audio <= 1'b0;
            end
         endcase
      end
   end

   assign Audio_Out = audio;
   assign Underrun  = underrun;
   assign Played    = played;

endmodule
`default_nettype wire

// File: doc/fifo_pdm_player.md
# fifo_pdm_player

- Read-side companion of the 1-bit microphone sample FIFO.
- Pops recorded PDM bits from the FIFO at a programmable sample rate and drives them onto a 1-bit audio output (speaker/low-pass filter pin).
- Supports bounded-length or play-until-empty playback, stop, underrun detection and optional FIFO flush on completion.
- Sits between the FIFO read port and the board audio pin; its control inputs come from the game/control logic.

## Interface

Parameters:
- DIV_W, 16: width of the sample-period divider.
- CNT_W, 21: width of the sample length/count. Must hold the FIFO depth, 200000.

Ports:
- Clk, in, 1: single system clock, all logic on its rising edge.
- Rst, in, 1: synchronous, active-high reset.
- Start, in, 1: one-cycle pulse that begins playback; only honoured in IDLE.
- Stop, in, 1: one-cycle pulse that ends playback.
- Div, in, DIV_W: sample period minus 1, in Clk cycles; latched on Start.
- Len, in, CNT_W: number of samples to play; 0 means play until the FIFO is empty. Latched on Start.
- ClrOnDone, in, 1: when 1, flush the FIFO at the end of playback; latched on Start.
- F_Data, in, 1: FIFO data at the current read pointer. It is show-ahead: valid whenever F_EmptyN=1.
- F_EmptyN, in, 1: FIFO not-empty flag, low = empty.
- FOutN, out, 1: active-low FIFO read strobe, exactly 1 cycle low per popped sample.
- FClrN, out, 1: active-low FIFO clear.
- Audio_Out, out, 1: PDM audio bit.
- Audio_En, out, 1: amplifier enable, high only while playing.
- Busy, out, 1: playback in progress.
- Done, out, 1: one-cycle pulse when playback ends.
- Underrun, out, 1: sticky flag; FIFO was empty at a sample tick during bounded playback.
- Played, out, CNT_W: samples popped in the current or last run.

## Operation

- States: IDLE, RUN, DONE.
- IDLE:
  - Outputs: FOutN=1, FClrN=1, Audio_Out=0, Audio_En=0, Busy=0.
  - Start=1 with Stop=0: latch Div, Len, ClrOnDone; clear Played and Underrun; load div_cnt=Div; go to RUN.
  - Start and Stop in the same cycle: stay in IDLE.
- RUN:
  - Busy=1, Audio_En=1.
  - div_cnt decrements each cycle. A tick is a cycle with div_cnt==0; the tick reloads div_cnt with Div.
  - Tick with F_EmptyN=1 and Stop=0:
    - FOutN=0 in that cycle (combinational decode of the state, div_cnt and F_EmptyN).
    - Audio_Out<=F_Data; Played<=Played+1.
  - Tick with F_EmptyN=0:
    - No read; FOutN stays 1.
    - Len==0: normal end, go to DONE; Underrun is not set.
    - Len!=0: Underrun<=1; Audio_Out<=~Audio_Out (PDM mid-scale silence); stay in RUN.
  - After the read that makes Played==Len (Len!=0): go to DONE.
  - Stop=1: go to DONE at the next edge. Stop overrides a tick in the same cycle: no read, Audio_Out holds.
  - Start in RUN: ignored.
- DONE (one cycle):
  - Done=1, Busy=0, Audio_En=0, Audio_Out<=0.
  - FClrN=0 for this cycle if the latched ClrOnDone=1, which discards the remaining samples.
  - Next state IDLE.
- Played and Underrun hold their values after DONE until the next accepted Start.
- Played counts modulo 2^CNT_W; it cannot wrap within a legal Len.

## Timing

- Rst (synchronous, any state, including mid-RUN):
  - State returns to IDLE; div_cnt=0, Played=0, Underrun=0, Audio_Out=0.
  - FOutN=1, FClrN=1, Audio_En=0, Busy=0, Done=0.
  - No read strobe is issued in the reset cycle.
- Start sampled high in cycle k: cycle k+1 is the first RUN cycle, div_cnt=Div.
- First tick is cycle k+1+Div; subsequent ticks every Div+1 cycles.
- Div=0: a tick every cycle, so back-to-back reads with FOutN held low continuously while data is available.
- Audio_Out changes only at the edge ending a tick cycle (or in DONE/Rst). It is stable for Div+1 cycles.
- Last read at tick cycle t: DONE is cycle t+1, IDLE is cycle t+2. Done is high only in cycle t+1.
- FOutN is never low while F_EmptyN=0, never low outside RUN, and never low in the same cycle as FClrN=0.

## Test plan

- Reset: hold Rst 2 cycles mid-stream → FOutN=1, FClrN=1, Audio_Out=0, Audio_En=0, Busy=0, Done=0, Underrun=0, Played=0.
- Preload FIFO with 1,0,1,1,0,0,1,0; Div=3, Len=8; Start at cycle k:
  - FOutN low in cycles k+4, k+8, …, k+32.
  - Audio_Out follows 1,0,1,1,0,0,1,0, each bit held 4 cycles.
  - Done in cycle k+33; Played=8; Underrun=0.
- Preload 3 bits; Len=0, Div=1 → 3 reads spaced 2 cycles apart; the next tick finds FIFO empty → Done; Underrun=0; Played=3.
- Preload 3 bits; Len=5, Div=1:
  - After 3 reads, Audio_Out toggles on each tick and Underrun=1.
  - Stop → Done next cycle; Played=3.
- Preload 10 bits; ClrOnDone=1, Div=0:
  - 4 consecutive FOutN-low cycles.
  - Stop asserted in the 5th tick cycle → no 5th read; FClrN low exactly in the Done cycle; FIFO reports empty afterwards.
- Start with Stop in the same cycle, then Start during RUN → both ignored (the first leaves the block in IDLE; the second neither restarts nor changes Played or div_cnt).
